frame_line_buffer: RTL and testbench

- Parametrised successor to the photo-frame SRAM controller. Loads one received image into single-port SRAM, then streams it to the display through ping-pong line buffers.
- One buffer is filled from SRAM while the display scans the other. Buffer roles swap on each line request.
- Adds pipelined SRAM reads with configurable latency, an explicit display window, overrun detection and a handshake on the receive side.
- Sits between the UART pixel assembler, the external SRAM port and the VGA/LCD timing generator.

---
 rtl/frame_line_buffer.sv | 237 +++++++++++++++++++++++
 tb/tb_frame_line_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_line_buffer.sv
// frame_line_buffer: stores one received image in single-port SRAM and streams
// it to the display through two ping-pong line buffers. One buffer is filled from
// SRAM (pipelined reads, RD_LAT cycles) while the display scans the other. The
// buffer roles swap on every line request.
// Optional feature macro: FLB_MIRROR_EN (store each row mirrored horizontally).
module frame_line_buffer #(
    parameter int IMG_W     = 200,
    parameter int IMG_H     = 150,
    parameter int PIX_W     = 12,
    parameter int ADDR_W    = 15,
    parameter int ROW_START = 224,
    parameter int RD_LAT    = 1,
    parameter int X_W       = $clog2(IMG_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              rx_valid,
    input  logic [PIX_W-1:0]  rx_data,
    output logic              rx_ready,
    output logic              load_done,
    input  logic              line_req,
    input  logic [9:0]        y_addr,
    input  logic [X_W-1:0]    x_rd,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              fill_overrun,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [PIX_W-1:0]  sram_wdata,
    output logic              sram_wre,
    input  logic [PIX_W-1:0]  sram_rdata
);

    localparam int                COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [X_W-1:0]    X_LIMIT  = X_W'(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DISP = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic              load_done_q;
    logic              fill_overrun_q;
    logic              front_sel_q;
    logic              back_sel;
    logic [1:0]        valid_q;
    logic [X_W-1:0]    rd_cnt_q;
    logic [COL_W-1:0]  cap_cnt_q;
    logic [COL_W-1:0]  cap_col;
    logic [COL_W-1:0]  x_idx;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [PIX_W-1:0]  pixel_q;
    logic [PIX_W-1:0]  line_mem [2][IMG_W];

    logic mode_disp, in_window, first_row;
    logic wr_fire, issue, capture, fill_start, swap_only, fill_done;
    logic overrun_set, load_enter;

    assign mode_disp = (mode == 2'd2);
    assign in_window = (int'(y_addr) >= ROW_START - 1) && (int'(y_addr) <= ROW_START + IMG_H - 2);
    // Fill row r = y_addr - ROW_START + 1; only r == 0 matters, it restarts the running base.
    assign first_row = (int'(y_addr) == ROW_START - 1);
    assign back_sel  = ~front_sel_q;
    assign x_idx     = x_rd[COL_W-1:0];
    assign capture   = (state_q == S_FILL) && vld_q[RD_LAT-1];

`ifdef FLB_MIRROR_EN
    assign cap_col = LAST_COL - cap_cnt_q;
`else
    assign cap_col = cap_cnt_q;
`endif

    // Next-state decode, SRAM port drive and per-cycle event strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        rx_ready    = 1'b0;
        sram_wre    = 1'b0;
        sram_addr   = '0;
        sram_wdata  = '0;
        wr_fire     = 1'b0;
        issue       = 1'b0;
        fill_start  = 1'b0;
        swap_only   = 1'b0;
        fill_done   = 1'b0;
        overrun_set = 1'b0;
        load_enter  = 1'b0;

        unique case (state_q)
            S_IDLE: ;
            S_LOAD: begin
                rx_ready = !load_done_q;
                if (rx_valid && !load_done_q) begin
                    wr_fire    = 1'b1;
                    sram_wre   = 1'b1;
                    sram_addr  = wr_cnt_q;
                    sram_wdata = rx_data;
                end
            end
            S_DISP: begin
                if (line_req && mode_disp) begin
                    if (load_done_q && in_window) begin
                        fill_start = 1'b1;
                        state_d    = S_FILL;
                    end else begin
                        swap_only = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (rd_cnt_q < X_LIMIT && mode_disp) begin
                    issue     = 1'b1;
                    sram_addr = base_q + ADDR_W'(rd_cnt_q);
                end
                overrun_set = line_req;
                if (capture && cap_cnt_q == LAST_COL && mode_disp) begin
                    fill_done = 1'b1;
                    state_d   = S_DISP;
                end
            end
            default: ;
        endcase

        // Mode has priority over the per-state transitions above.
        unique case (mode)
            2'd1: begin
                if (state_q != S_LOAD) begin
                    state_d    = S_LOAD;
                    load_enter = 1'b1;
                end
            end
            2'd2: begin
                if (state_q == S_IDLE || state_q == S_LOAD) state_d = S_DISP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-tag shift register: bit i marks an address issued i+1 cycles ago.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignment.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Load write counter and frame-complete flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q    <= '0;
            load_done_q <= 1'b0;
        end else if (load_enter) begin
            wr_cnt_q    <= '0;
            load_done_q <= 1'b0;
        end else if (wr_fire) begin
            if (wr_cnt_q == LAST_PIX) begin
                wr_cnt_q    <= '0;
                load_done_q <= 1'b1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    // Buffer roles, valid bits, running row base and the sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_sel_q    <= 1'b0;
            valid_q        <= '0;
            base_q         <= '0;
            fill_overrun_q <= 1'b0;
        end else begin
            if (load_enter) begin
                valid_q        <= '0;
                fill_overrun_q <= 1'b0;
            end else begin
                if (overrun_set) fill_overrun_q <= 1'b1;
                if (fill_start || swap_only) begin
                    // Old front becomes the back buffer and is stale until refilled.
                    front_sel_q          <= back_sel;
                    valid_q[front_sel_q] <= 1'b0;
                end else if (fill_done) begin
                    valid_q[back_sel] <= 1'b1;
                end
            end
            if (fill_start) base_q <= first_row ? '0 : base_q + ROW_STEP;
        end
    end

    // Fill pipeline: issue counter, capture counter, in-flight tags; cleared outside S_FILL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            vld_q     <= '0;
        end else if (state_q != S_FILL) begin
            rd_cnt_q  <= '0;
            cap_cnt_q <= '0;
            vld_q     <= '0;
        end else begin
            if (issue)   rd_cnt_q  <= rd_cnt_q + 1'b1;
            if (capture) cap_cnt_q <= cap_cnt_q + 1'b1;
            vld_q <= vld_d;
        end
    end

    // Capture returning SRAM words into the back buffer.
    always_ff @(posedge clk) begin
        // NOTE: line storage has no reset; the valid bits decide whether it is shown.
        if (capture) line_mem[back_sel][cap_col] <= sram_rdata;
    end

    // Registered display pixel from the front buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      pixel_q <= '0;
        else if (valid_q[front_sel_q] && x_rd < X_LIMIT) pixel_q <= line_mem[front_sel_q][x_idx];
        else                                          pixel_q <= '0;
    end

    assign load_done    = load_done_q;
    assign fill_overrun = fill_overrun_q;
    assign pixel_out    = pixel_q;

endmodule

// File: tb/tb_frame_line_buffer.sv
// Directed bench for frame_line_buffer: IMG_W=4, IMG_H=3, ROW_START=10, RD_LAT=2.
// Pixel value loaded at SRAM address a is a. Define FLB_MIRROR_EN to expect mirrored rows.
module tb_frame_line_buffer;

    localparam int IMG_W     = 4;
    localparam int IMG_H     = 3;
    localparam int PIX_W     = 12;
    localparam int ADDR_W    = 4;
    localparam int ROW_START = 10;
    localparam int RD_LAT    = 2;
    localparam int X_W       = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        mode;
    logic              rx_valid;
    logic [PIX_W-1:0]  rx_data;
    logic              rx_ready;
    logic              load_done;
    logic              line_req;
    logic [9:0]        y_addr;
    logic [X_W-1:0]    x_rd;
    logic [PIX_W-1:0]  pixel_out;
    logic              fill_overrun;
    logic [ADDR_W-1:0] sram_addr;
    logic [PIX_W-1:0]  sram_wdata;
    logic              sram_wre;
    logic [PIX_W-1:0]  sram_rdata;

    int total = 0;
    int bad   = 0;

    frame_line_buffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
        .ROW_START(ROW_START), .RD_LAT(RD_LAT), .X_W(X_W)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .load_done(load_done), .line_req(line_req), .y_addr(y_addr),
        .x_rd(x_rd), .pixel_out(pixel_out), .fill_overrun(fill_overrun),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wre(sram_wre),
        .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model with a two-cycle read pipeline.
    logic [PIX_W-1:0] mem [16];
    logic [PIX_W-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (sram_wre) mem[sram_addr] <= sram_wdata;
        rd_p1 <= mem[sram_addr];
        rd_p2 <= rd_p1;
    end
    assign sram_rdata = rd_p2;

    function automatic int exp_pix(input int row, input int x);
`ifdef FLB_MIRROR_EN
        return row * IMG_W + (IMG_W - 1 - x);
`else
        return row * IMG_W + x;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; rx_valid = 1'b0; rx_data = '0;
        line_req = 1'b0; y_addr = '0; x_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rx_ready, load_done, fill_overrun, sram_wre} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b expected 0000", {rx_ready, load_done, fill_overrun, sram_wre});
        end
        total++;
        if (sram_addr !== '0 || sram_wdata !== '0 || pixel_out !== '0) begin
            bad++; $display("FAIL reset_data: addr=%0d wdata=%0d pix=%0d expected all 0", sram_addr, sram_wdata, pixel_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load();
        mode = 2'd1;
        tick();
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            rx_valid = 1'b1; rx_data = PIX_W'(i);
            #1;
            total++;
            if (sram_wre !== 1'b1 || sram_addr !== ADDR_W'(i) || sram_wdata !== PIX_W'(i) || rx_ready !== 1'b1) begin
                bad++; $display("FAIL load_write[%0d]: wre=%b addr=%0d wdata=%0d rdy=%b expected 1/%0d/%0d/1", i, sram_wre, sram_addr, sram_wdata, rx_ready, i, i);
            end
            if (i == IMG_W * IMG_H - 1) begin
                total++;
                if (load_done !== 1'b0) begin
                    bad++; $display("FAIL load_done_early: got %b expected 0", load_done);
                end
            end
            tick();
        end
        total++;
        if (load_done !== 1'b1 || rx_ready !== 1'b0) begin
            bad++; $display("FAIL load_complete: done=%b rdy=%b expected 1/0", load_done, rx_ready);
        end
        rx_data = 12'd99;
        #1;
        total++;
        if (sram_wre !== 1'b0) begin
            bad++; $display("FAIL load_extra_ignored: wre=%b expected 0", sram_wre);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_first_fill();
        mode = 2'd2;
        tick();
        line_req = 1'b1; y_addr = 10'd9;
        tick();
        line_req = 1'b0;
        for (int c = 0; c < IMG_W; c++) begin
            #1;
            total++;
            if (sram_addr !== ADDR_W'(c) || sram_wre !== 1'b0) begin
                bad++; $display("FAIL fill0_addr[%0d]: addr=%0d wre=%b expected %0d/0", c, sram_addr, sram_wre, c);
            end
            tick();
        end
        total++;
        if (sram_addr !== '0) begin
            bad++; $display("FAIL fill0_stop: addr=%0d expected 0", sram_addr);
        end
        repeat (2) tick();
        // Exactly IMG_W+RD_LAT cycles after entry: fill must be done, so this is not an overrun.
        line_req = 1'b1; y_addr = 10'd10;
        tick();
        line_req = 1'b0;
        for (int j = 0; j < IMG_W; j++) begin
            x_rd = X_W'(j);
            #1;
            total++;
            if (sram_addr !== ADDR_W'(4 + j)) begin
                bad++; $display("FAIL fill1_addr[%0d]: addr=%0d expected %0d", j, sram_addr, 4 + j);
            end
            tick();
            total++;
            if (pixel_out !== PIX_W'(exp_pix(0, j))) begin
                bad++; $display("FAIL row0_pixel[%0d]: got %0d expected %0d", j, pixel_out, exp_pix(0, j));
            end
        end
        repeat (2) tick();
        total++;
        if (fill_overrun !== 1'b0) begin
            bad++; $display("FAIL no_overrun: got %b expected 0", fill_overrun);
        end
    endtask

    task automatic test_last_row();
        line_req = 1'b1; y_addr = 10'd11;
        tick();
        line_req = 1'b0;
        repeat (6) tick();
        line_req = 1'b1; y_addr = 10'd12;
        tick();
        line_req = 1'b0;
        #1;
        total++;
        if (sram_addr !== '0) begin
            bad++; $display("FAIL outside_no_fill: addr=%0d expected 0", sram_addr);
        end
        for (int j = 0; j < IMG_W; j++) begin
            x_rd = X_W'(j);
            tick();
            total++;
            if (pixel_out !== PIX_W'(exp_pix(2, j))) begin
                bad++; $display("FAIL row2_pixel[%0d]: got %0d expected %0d", j, pixel_out, exp_pix(2, j));
            end
        end
        x_rd = X_W'(4);
        tick();
        total++;
        if (pixel_out !== '0) begin
            bad++; $display("FAIL x_out_of_range: got %0d expected 0", pixel_out);
        end
        line_req = 1'b1; y_addr = 10'd13;
        tick();
        line_req = 1'b0;
        for (int j = 0; j < IMG_W; j++) begin
            x_rd = X_W'(j);
            tick();
            total++;
            if (pixel_out !== '0) begin
                bad++; $display("FAIL below_image[%0d]: got %0d expected 0", j, pixel_out);
            end
        end
    endtask

    task automatic test_overrun();
        line_req = 1'b1; y_addr = 10'd9;
        tick();
        line_req = 1'b0;
        tick();
        tick();
        line_req = 1'b1; y_addr = 10'd10;
        #1;
        total++;
        if (sram_addr !== ADDR_W'(2)) begin
            bad++; $display("FAIL overrun_addr2: addr=%0d expected 2", sram_addr);
        end
        tick();
        line_req = 1'b0;
        #1;
        total++;
        if (fill_overrun !== 1'b1 || sram_addr !== ADDR_W'(3)) begin
            bad++; $display("FAIL overrun_flag: flag=%b addr=%0d expected 1/3", fill_overrun, sram_addr);
        end
        repeat (3) tick();
        line_req = 1'b1; y_addr = 10'd10;
        tick();
        line_req = 1'b0;
        for (int j = 0; j < IMG_W; j++) begin
            x_rd = X_W'(j);
            tick();
            total++;
            if (pixel_out !== PIX_W'(exp_pix(0, j))) begin
                bad++; $display("FAIL overrun_row0[%0d]: got %0d expected %0d", j, pixel_out, exp_pix(0, j));
            end
        end
        repeat (2) tick();
        total++;
        if (fill_overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_sticky: got %b expected 1", fill_overrun);
        end
    endtask

    task automatic test_abort();
        line_req = 1'b1; y_addr = 10'd9;
        tick();
        line_req = 1'b0;
        repeat (6) tick();
        line_req = 1'b1; y_addr = 10'd10;
        tick();
        line_req = 1'b0;
        #1;
        total++;
        if (sram_addr !== ADDR_W'(4)) begin
            bad++; $display("FAIL abort_first_addr: addr=%0d expected 4", sram_addr);
        end
        tick();
        mode = 2'd0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (sram_addr !== '0 || sram_wre !== 1'b0) begin
                bad++; $display("FAIL abort_no_read[%0d]: addr=%0d wre=%b expected 0/0", k, sram_addr, sram_wre);
            end
            tick();
        end
        mode = 2'd2;
        tick();
        x_rd = X_W'(1);
        tick();
        total++;
        if (pixel_out !== PIX_W'(exp_pix(0, 1))) begin
            bad++; $display("FAIL abort_front_kept: got %0d expected %0d", pixel_out, exp_pix(0, 1));
        end
        line_req = 1'b1; y_addr = 10'd12;
        tick();
        line_req = 1'b0;
        x_rd = X_W'(0);
        tick();
        total++;
        if (pixel_out !== '0) begin
            bad++; $display("FAIL abort_back_invalid: got %0d expected 0", pixel_out);
        end
    endtask

    task automatic test_reset_reload();
        mode = 2'd1;
        tick();
        total++;
        if (fill_overrun !== 1'b0 || load_done !== 1'b0) begin
            bad++; $display("FAIL load_entry_clear: ovr=%b done=%b expected 0/0", fill_overrun, load_done);
        end
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = PIX_W'(100 + i);
            tick();
        end
        rx_data = PIX_W'(105);
        rst = 1'b1;
        #1;
        total++;
        if ({sram_wre, rx_ready, load_done, fill_overrun} !== 4'b0000 || sram_addr !== '0 || sram_wdata !== '0 || pixel_out !== '0) begin
            bad++; $display("FAIL async_reset: wre=%b rdy=%b addr=%0d wdata=%0d expected all 0", sram_wre, rx_ready, sram_addr, sram_wdata);
        end
        rx_valid = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        tick();
        for (int i = 0; i < IMG_W * IMG_H; i++) begin
            rx_valid = 1'b1; rx_data = PIX_W'(i);
            #1;
            total++;
            if (sram_wre !== 1'b1 || sram_addr !== ADDR_W'(i)) begin
                bad++; $display("FAIL reload_write[%0d]: wre=%b addr=%0d expected 1/%0d", i, sram_wre, sram_addr, i);
            end
            tick();
        end
        rx_valid = 1'b0;
        total++;
        if (load_done !== 1'b1) begin
            bad++; $display("FAIL reload_done: got %b expected 1", load_done);
        end
        mode = 2'd2;
        tick();
        line_req = 1'b1; y_addr = 10'd9;
        tick();
        line_req = 1'b0;
        repeat (6) tick();
        line_req = 1'b1; y_addr = 10'd10;
        tick();
        line_req = 1'b0;
        for (int j = 0; j < IMG_W; j++) begin
            x_rd = X_W'(j);
            tick();
            total++;
            if (pixel_out !== PIX_W'(exp_pix(0, j))) begin
                bad++; $display("FAIL reload_row0[%0d]: got %0d expected %0d", j, pixel_out, exp_pix(0, j));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_first_fill();
        test_last_row();
        test_overrun();
        test_abort();
        test_reset_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
